mips_exe_path: RTL and testbench

- Execute section of the 5-stage MIPS pipeline: ID/EX pipeline register, EX-stage ALU with operand muxes, destination-register select, and EX/MEM pipeline register, in one block.
- Inputs: decoded operands and controller signals from the ID stage. Outputs: registered ALU result, store data, destination register, PC+4 and MEM/WB control to the MEM stage.

---
 rtl/mips_pkg.sv | 55 +++++
 rtl/mips_alu.sv | 33 +++
 rtl/mips_exe_path.sv | 130 +++++++++++++
 tb/tb_mips_exe_path.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS execute path: ALU opcodes, RegDst encodings,
// and the packed layouts of the ID/EX and EX/MEM pipeline registers.
package mips_pkg;

   localparam int REG_W = 5;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_XOR = 4'b0011;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_SLL = 4'b1000;
   localparam logic [3:0] ALU_SRL = 4'b1001;
   localparam logic [3:0] ALU_SRA = 4'b1010;
   localparam logic [3:0] ALU_LUI = 4'b1011;
   localparam logic [3:0] ALU_NOR = 4'b1100;

   localparam logic [1:0] RD_RT = 2'b00;
   localparam logic [1:0] RD_RD = 2'b01;
   localparam logic [1:0] RD_RA = 2'b10;

   typedef struct packed {
      logic [31:0]      pc_plus4;
      logic [31:0]      read_data1;
      logic [31:0]      read_data2;
      logic [31:0]      inst_extended;
      logic [REG_W-1:0] rt;
      logic [REG_W-1:0] rd;
      logic [REG_W-1:0] shamt;
      logic [1:0]       reg_dst;
      logic [3:0]       alu_op;
      logic             alu_src;
      logic             alu_src1;
      logic             mem_read;
      logic             mem_write;
      logic             mem_to_reg;
      logic             data_c;
      logic             reg_write;
   } id_ex_t;

   typedef struct packed {
      logic [31:0]      alu_result;
      logic [31:0]      write_data;
      logic [31:0]      pc_plus4;
      logic [REG_W-1:0] write_reg;
      logic             zero;
      logic             mem_read;
      logic             mem_write;
      logic             mem_to_reg;
      logic             data_c;
      logic             reg_write;
   } ex_mem_t;

endpackage

// File: rtl/mips_alu.sv
// Combinational 32-bit EX-stage ALU; shift amounts come from operand A[4:0]
// so the shamt mux in the top can feed shifts directly.
module mips_alu
   import mips_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [3:0]  op,
   output logic [31:0] result,
   output logic        zero
);

   always_comb begin
      result = 32'd0;
      case (op)
         ALU_AND: result = a & b;
         ALU_OR:  result = a | b;
         ALU_ADD: result = a + b;
         ALU_SUB: result = a - b;
         ALU_SLT: result = {31'd0, ($signed(a) < $signed(b))};
         ALU_NOR: result = ~(a | b);
         ALU_XOR: result = a ^ b;
         ALU_SLL: result = b << a[4:0];
         ALU_SRL: result = b >> a[4:0];
         ALU_SRA: result = $unsigned($signed(b) >>> a[4:0]);
         ALU_LUI: result = {b[15:0], 16'd0};
         default: result = 32'd0;
      endcase
   end

   assign zero = (result == 32'd0);

endmodule

// File: rtl/mips_exe_path.sv
// Execute section of the 5-stage MIPS pipeline: ID/EX register, ALU with
// operand muxes, destination select, and EX/MEM register.
module mips_exe_path
   import mips_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             freeze,
   input  logic [31:0]      pc_plus4_in,
   input  logic [31:0]      read_data1_in,
   input  logic [31:0]      read_data2_in,
   input  logic [31:0]      inst_extended_in,
   input  logic [REG_W-1:0] rt_in,
   input  logic [REG_W-1:0] rd_in,
   input  logic [REG_W-1:0] shamt_in,
   input  logic [1:0]       reg_dst_in,
   input  logic [3:0]       alu_op_in,
   input  logic             alu_src_in,
   input  logic             alu_src1_in,
   input  logic             mem_read_in,
   input  logic             mem_write_in,
   input  logic             mem_to_reg_in,
   input  logic             data_c_in,
   input  logic             reg_write_in,
   output logic [31:0]      alu_result_mem,
   output logic [31:0]      write_data_mem,
   output logic [REG_W-1:0] write_reg_mem,
   output logic [31:0]      pc_plus4_mem,
   output logic             zero_mem,
   output logic             mem_read_mem,
   output logic             mem_write_mem,
   output logic             mem_to_reg_mem,
   output logic             data_c_mem,
   output logic             reg_write_mem
);

   id_ex_t           id_ex;
   id_ex_t           id_ex_next;
   ex_mem_t          ex_mem;
   ex_mem_t          ex_mem_next;
   logic [31:0]      op_a;
   logic [31:0]      op_b;
   logic [31:0]      alu_result;
   logic             alu_zero;
   logic [REG_W-1:0] write_reg;

   assign id_ex_next = '{
      pc_plus4:      pc_plus4_in,
      read_data1:    read_data1_in,
      read_data2:    read_data2_in,
      inst_extended: inst_extended_in,
      rt:            rt_in,
      rd:            rd_in,
      shamt:         shamt_in,
      reg_dst:       reg_dst_in,
      alu_op:        alu_op_in,
      alu_src:       alu_src_in,
      alu_src1:      alu_src1_in,
      mem_read:      mem_read_in,
      mem_write:     mem_write_in,
      mem_to_reg:    mem_to_reg_in,
      data_c:        data_c_in,
      reg_write:     reg_write_in
   };

   assign op_a = id_ex.alu_src1 ? {27'd0, id_ex.shamt} : id_ex.read_data1;
   assign op_b = id_ex.alu_src  ? id_ex.inst_extended  : id_ex.read_data2;

   mips_alu u_alu (
      .a      (op_a),
      .b      (op_b),
      .op     (id_ex.alu_op),
      .result (alu_result),
      .zero   (alu_zero)
   );

   // The unused 2'b11 encoding falls back to rt, same as I-type.
   always_comb begin
      write_reg = id_ex.rt;
      case (id_ex.reg_dst)
         RD_RD:   write_reg = id_ex.rd;
         RD_RA:   write_reg = 5'd31;
         default: write_reg = id_ex.rt;
      endcase
   end

   assign ex_mem_next = '{
      alu_result: alu_result,
      write_data: id_ex.read_data2,
      pc_plus4:   id_ex.pc_plus4,
      write_reg:  write_reg,
      zero:       alu_zero,
      mem_read:   id_ex.mem_read,
      mem_write:  id_ex.mem_write,
      mem_to_reg: id_ex.mem_to_reg,
      data_c:     id_ex.data_c,
      reg_write:  id_ex.reg_write
   };

   // Flush beats freeze: a flushed slot still lets the EX instruction advance.
   always_ff @(posedge clk) begin
      if (rst) begin
         id_ex  <= '0;
         ex_mem <= '0;
      end else begin
         if (flush)
            id_ex <= '0;
         else if (!freeze)
            id_ex <= id_ex_next;

         if (freeze && !flush)
            ex_mem <= '0;
         else
            ex_mem <= ex_mem_next;
      end
   end

   assign alu_result_mem = ex_mem.alu_result;
   assign write_data_mem = ex_mem.write_data;
   assign write_reg_mem  = ex_mem.write_reg;
   assign pc_plus4_mem   = ex_mem.pc_plus4;
   assign zero_mem       = ex_mem.zero;
   assign mem_read_mem   = ex_mem.mem_read;
   assign mem_write_mem  = ex_mem.mem_write;
   assign mem_to_reg_mem = ex_mem.mem_to_reg;
   assign data_c_mem     = ex_mem.data_c;
   assign reg_write_mem  = ex_mem.reg_write;

endmodule

// File: tb/tb_mips_exe_path.sv
// Self-checking bench for mips_exe_path: a transaction-level model of the two
// pipeline slots checked every cycle, plus hand-computed literal expectations.
module tb_mips_exe_path;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] imm;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [4:0]  shamt;
      logic [1:0]  regDst;
      logic [3:0]  op;
      logic        aluSrc;
      logic        aluSrc1;
      logic        memRead;
      logic        memWrite;
      logic        memToReg;
      logic        dataC;
      logic        regWrite;
   } instr_t;

   typedef struct packed {
      logic [31:0] alu;
      logic [31:0] wdata;
      logic [31:0] pc;
      logic [4:0]  wreg;
      logic        zero;
      logic        memRead;
      logic        memWrite;
      logic        memToReg;
      logic        dataC;
      logic        regWrite;
   } out_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        freeze = 1'b0;
   instr_t      cur = '0;

   logic [31:0] alu_result_mem, write_data_mem, pc_plus4_mem;
   logic [4:0]  write_reg_mem;
   logic        zero_mem, mem_read_mem, mem_write_mem, mem_to_reg_mem, data_c_mem, reg_write_mem;

   int          vectors = 0;
   int          miscompares = 0;
   logic        checkEn = 1'b0;
   instr_t      heldInstr = '0;
   out_t        expOut = '0;
   out_t        dutOut;

   always #5 clk = ~clk;

   mips_exe_path dut (
      .clk              (clk),
      .rst              (rst),
      .flush            (flush),
      .freeze           (freeze),
      .pc_plus4_in      (cur.pc),
      .read_data1_in    (cur.rd1),
      .read_data2_in    (cur.rd2),
      .inst_extended_in (cur.imm),
      .rt_in            (cur.rt),
      .rd_in            (cur.rd),
      .shamt_in         (cur.shamt),
      .reg_dst_in       (cur.regDst),
      .alu_op_in        (cur.op),
      .alu_src_in       (cur.aluSrc),
      .alu_src1_in      (cur.aluSrc1),
      .mem_read_in      (cur.memRead),
      .mem_write_in     (cur.memWrite),
      .mem_to_reg_in    (cur.memToReg),
      .data_c_in        (cur.dataC),
      .reg_write_in     (cur.regWrite),
      .alu_result_mem   (alu_result_mem),
      .write_data_mem   (write_data_mem),
      .write_reg_mem    (write_reg_mem),
      .pc_plus4_mem     (pc_plus4_mem),
      .zero_mem         (zero_mem),
      .mem_read_mem     (mem_read_mem),
      .mem_write_mem    (mem_write_mem),
      .mem_to_reg_mem   (mem_to_reg_mem),
      .data_c_mem       (data_c_mem),
      .reg_write_mem    (reg_write_mem)
   );

   assign dutOut = {alu_result_mem, write_data_mem, pc_plus4_mem, write_reg_mem, zero_mem,
                    mem_read_mem, mem_write_mem, mem_to_reg_mem, data_c_mem, reg_write_mem};

   // What the EX/MEM slot must hold once instruction i has passed through EX.
   function automatic out_t execute(input instr_t i);
      out_t        o;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] r;
      int          sh;
      a  = i.aluSrc1 ? 32'(i.shamt) : i.rd1;
      b  = i.aluSrc ? i.imm : i.rd2;
      sh = int'(a % 32);
      case (i.op)
         4'b0000: r = a & b;
         4'b0001: r = a | b;
         4'b0010: r = a + b;
         4'b0110: r = a - b;
         4'b0111: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'b1100: r = ~(a | b);
         4'b0011: r = a ^ b;
         4'b1000: r = b << sh;
         4'b1001: r = b >> sh;
         4'b1010: r = (b >> sh) | ((b[31] && sh != 0) ? ~(32'hFFFFFFFF >> sh) : 32'd0);
         4'b1011: r = b * 32'h10000;
         default: r = 32'd0;
      endcase
      o.alu      = r;
      o.zero     = (r == 32'd0);
      o.wdata    = i.rd2;
      o.pc       = i.pc;
      o.wreg     = (i.regDst == 2'b10) ? 5'd31 : (i.regDst == 2'b01) ? i.rd : i.rt;
      o.memRead  = i.memRead;
      o.memWrite = i.memWrite;
      o.memToReg = i.memToReg;
      o.dataC    = i.dataC;
      o.regWrite = i.regWrite;
      return o;
   endfunction

   function automatic instr_t mk(input logic [3:0] op, input logic [31:0] rd1, input logic [31:0] rd2,
                                 input logic [31:0] imm, input logic aluSrc);
      instr_t i;
      i        = '0;
      i.op     = op;
      i.rd1    = rd1;
      i.rd2    = rd2;
      i.imm    = imm;
      i.aluSrc = aluSrc;
      return i;
   endfunction

   task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input instr_t i, input logic fl, input logic fr, input logic rs);
      cur    = i;
      flush  = fl;
      freeze = fr;
      rst    = rs;
      @(posedge clk);
      #1;
   endtask

   // Model of the two pipeline slots, advanced on the same edges as the DUT.
   always @(posedge clk) begin
      if (rst) begin
         heldInstr <= '0;
         expOut    <= '0;
      end else begin
         expOut    <= (freeze && !flush) ? out_t'('0) : execute(heldInstr);
         heldInstr <= flush ? instr_t'('0) : (freeze ? heldInstr : cur);
      end
   end

   always @(negedge clk) begin
      if (checkEn)
         checkOutput("pipeline", 128'(dutOut), 128'(expOut));
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      instr_t noise, nop, x, t;
      logic [3:0] ops [8];
      nop = '0;

      noise          = mk(4'b0010, 32'd3, 32'd4, 32'h55, 1'b0);
      noise.pc       = 32'h1234;
      noise.rt       = 5'd2;
      noise.rd       = 5'd3;
      noise.shamt    = 5'd1;
      noise.regDst   = 2'b01;
      noise.regWrite = 1'b1;
      noise.memRead  = 1'b1;

      // Reset with live inputs.
      applyStimulus(noise, 1'b0, 1'b0, 1'b1);
      applyStimulus(noise, 1'b0, 1'b0, 1'b1);
      checkOutput("rst_alu",   128'(alu_result_mem), 128'(32'd0));
      checkOutput("rst_wreg",  128'(write_reg_mem),  128'(5'd0));
      checkOutput("rst_rw",    128'(reg_write_mem),  128'(1'b0));
      checkOutput("rst_pc",    128'(pc_plus4_mem),   128'(32'd0));
      checkOutput("rst_zero",  128'(zero_mem),       128'(1'b0));
      checkOutput("rst_mr",    128'(mem_read_mem),   128'(1'b0));
      checkEn = 1'b1;

      applyStimulus(noise, 1'b0, 1'b0, 1'b0);
      applyStimulus(noise, 1'b0, 1'b0, 1'b0);
      checkOutput("post_rst_alu",  128'(alu_result_mem), 128'(32'd7));
      checkOutput("post_rst_wreg", 128'(write_reg_mem),  128'(5'd3));

      // R-type add with wraparound into the sign bit.
      x          = mk(4'b0010, 32'h7FFFFFFF, 32'h1, 32'h0, 1'b0);
      x.regDst   = 2'b01;
      x.rd       = 5'd9;
      x.rt       = 5'd4;
      x.regWrite = 1'b1;
      applyStimulus(x, 1'b0, 1'b0, 1'b0);
      applyStimulus(nop, 1'b0, 1'b0, 1'b0);
      checkOutput("add_alu",  128'(alu_result_mem), 128'(32'h80000000));
      checkOutput("add_wreg", 128'(write_reg_mem),  128'(5'd9));
      checkOutput("add_rw",   128'(reg_write_mem),  128'(1'b1));
      checkOutput("add_zero", 128'(zero_mem),       128'(1'b0));

      // Immediate sub giving zero.
      applyStimulus(mk(4'b0110, 32'd5, 32'd77, 32'd5, 1'b1), 1'b0, 1'b0, 1'b0);
      applyStimulus(nop, 1'b0, 1'b0, 1'b0);
      checkOutput("subi_alu",  128'(alu_result_mem), 128'(32'd0));
      checkOutput("subi_zero", 128'(zero_mem),       128'(1'b1));

      // Store: address from immediate, data from rt.
      x          = mk(4'b0010, 32'h100, 32'hDEADBEEF, 32'd4, 1'b1);
      x.memWrite = 1'b1;
      applyStimulus(x, 1'b0, 1'b0, 1'b0);
      applyStimulus(nop, 1'b0, 1'b0, 1'b0);
      checkOutput("sw_alu",   128'(alu_result_mem), 128'(32'h104));
      checkOutput("sw_wdata", 128'(write_data_mem), 128'(32'hDEADBEEF));
      checkOutput("sw_mw",    128'(mem_write_mem),  128'(1'b1));

      // Shifts by shamt, streamed back to back.
      x         = mk(4'b1001, 32'hFFFFFFFF, 32'hF0000000, 32'h0, 1'b0);
      x.aluSrc1 = 1'b1;
      x.shamt   = 5'd4;
      applyStimulus(x, 1'b0, 1'b0, 1'b0);
      x.op = 4'b1010;
      applyStimulus(x, 1'b0, 1'b0, 1'b0);
      checkOutput("srl_alu", 128'(alu_result_mem), 128'(32'h0F000000));
      applyStimulus(mk(4'b0111, 32'hFFFFFFFF, 32'd1, 32'h0, 1'b0), 1'b0, 1'b0, 1'b0);
      checkOutput("sra_alu", 128'(alu_result_mem), 128'(32'hFF000000));
      applyStimulus(nop, 1'b0, 1'b0, 1'b0);
      checkOutput("slt_alu", 128'(alu_result_mem), 128'(32'd1));

      // jal link.
      x          = nop;
      x.regDst   = 2'b10;
      x.dataC    = 1'b1;
      x.regWrite = 1'b1;
      x.pc       = 32'h40;
      x.rt       = 5'd6;
      applyStimulus(x, 1'b0, 1'b0, 1'b0);
      applyStimulus(nop, 1'b0, 1'b0, 1'b0);
      checkOutput("jal_wreg", 128'(write_reg_mem), 128'(5'd31));
      checkOutput("jal_dc",   128'(data_c_mem),    128'(1'b1));
      checkOutput("jal_pc",   128'(pc_plus4_mem),  128'(32'h40));

      // Flush squashes the incoming instruction.
      x          = mk(4'b0010, 32'd1, 32'd2, 32'd0, 1'b0);
      x.regWrite = 1'b1;
      x.memWrite = 1'b1;
      applyStimulus(x, 1'b1, 1'b0, 1'b0);
      applyStimulus(nop, 1'b0, 1'b0, 1'b0);
      checkOutput("flush_rw", 128'(reg_write_mem), 128'(1'b0));
      checkOutput("flush_mw", 128'(mem_write_mem), 128'(1'b0));

      // Freeze one cycle: bubble out, held instruction emerges a cycle late.
      x          = mk(4'b0010, 32'd10, 32'd20, 32'd0, 1'b0);
      x.regDst   = 2'b01;
      x.rd       = 5'd7;
      x.regWrite = 1'b1;
      applyStimulus(x, 1'b0, 1'b0, 1'b0);
      applyStimulus(nop, 1'b0, 1'b1, 1'b0);
      checkOutput("frz_bubble_alu", 128'(alu_result_mem), 128'(32'd0));
      checkOutput("frz_bubble_rw",  128'(reg_write_mem),  128'(1'b0));
      applyStimulus(nop, 1'b0, 1'b0, 1'b0);
      checkOutput("frz_late_alu",  128'(alu_result_mem), 128'(32'd30));
      checkOutput("frz_late_wreg", 128'(write_reg_mem),  128'(5'd7));

      // Reset while flush and freeze are both asserted, then resume.
      applyStimulus(x, 1'b1, 1'b1, 1'b1);
      checkOutput("rst_prio_alu", 128'(alu_result_mem), 128'(32'd0));
      checkOutput("rst_prio_rw",  128'(reg_write_mem),  128'(1'b0));
      applyStimulus(x, 1'b0, 1'b0, 1'b0);
      applyStimulus(nop, 1'b0, 1'b0, 1'b0);
      checkOutput("rst_resume_alu", 128'(alu_result_mem), 128'(32'd30));

      // Remaining ops, including an unused code, streamed through the model.
      ops = '{4'b0000, 4'b0001, 4'b0011, 4'b1100, 4'b1000, 4'b1011, 4'b0100, 4'b1111};
      foreach (ops[k]) begin
         t         = mk(ops[k], 32'h0F0F1234, 32'h00FF00F3, 32'h00001234, 1'b0);
         t.aluSrc1 = (ops[k] == 4'b1000);
         t.shamt   = 5'd8;
         t.aluSrc  = (ops[k] == 4'b1011);
         t.rt      = 5'(k + 1);
         applyStimulus(t, 1'b0, 1'b0, 1'b0);
      end
      applyStimulus(nop, 1'b0, 1'b0, 1'b0);
      applyStimulus(nop, 1'b0, 1'b0, 1'b0);

      t        = mk(4'b1011, 32'h0, 32'h0, 32'h00001234, 1'b1);
      applyStimulus(t, 1'b0, 1'b0, 1'b0);
      applyStimulus(nop, 1'b0, 1'b0, 1'b0);
      checkOutput("lui_alu", 128'(alu_result_mem), 128'(32'h12340000));
      applyStimulus(nop, 1'b0, 1'b0, 1'b0);

      @(negedge clk);
      checkEn = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
